// File: rtl/soc_bram_arb_pkg.sv
// Shared constants and types for the soc_bram_arb block-RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encodings, port identifiers and the response tag
// carried down the two-stage pipe alongside each RAM access.
package soc_bram_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // One entry per RAM access in flight; we is forced low on idle slots
    typedef struct packed {
        logic vld;
        logic port;
        logic we;
    } tag_t;

endpackage

// File: rtl/soc_bram_arb_if.sv
// Request/response and RAM-side bus of the soc_bram_arb arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per port; responses and RAM side have none.
//
// slave  : arbiter view (takes requests and bram_dout, drives grants, responses, RAM controls)
// master : requester/RAM-parent view (the opposite directions)
interface soc_bram_arb_if #(
    parameter int addr_width = 8,
    parameter int data_width = 8
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [1:0]            req_lock;
    logic [addr_width-1:0] req_addr0;
    logic [addr_width-1:0] req_addr1;
    logic [data_width-1:0] req_wdata0;
    logic [data_width-1:0] req_wdata1;
    logic [1:0]            rsp_valid;
    logic                  rsp_we;
    logic [data_width-1:0] rsp_rdata;
    logic                  bram_we;
    logic [addr_width-1:0] bram_addr;
    logic [data_width-1:0] bram_din;
    logic [data_width-1:0] bram_dout;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, bram_dout,
        output req_ready, rsp_valid, rsp_we, rsp_rdata,
               bram_we, bram_addr, bram_din
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, bram_dout,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata,
               bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/soc_bram_arb_grant.sv
// Two-way combinational grant for the block-RAM arbiter.
// Latency: 0 cycles (pure combinational).
// Backpressure: ready only ever asserted for a port whose valid is high; at most one bit set.
//
// Ports: valid[1:0], state (FSM), last_grant -> ready[1:0], last_grant_nxt.
// Build option SOC_BRAM_ARB_RR_EN: defined = round-robin on contention in IDLE,
// undefined = port 0 always wins contention. Locked states ignore the other port.
module soc_bram_arb_grant
    import soc_bram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic [1:0] state,
    input  logic       last_grant,
    output logic [1:0] ready,
    output logic       last_grant_nxt
);

    always_comb begin
        ready = 2'b00;
        case (state)
            ST_LOCK0: ready[PORT_CPU] = valid[PORT_CPU];
            ST_LOCK1: ready[PORT_DMA] = valid[PORT_DMA];
            default: begin
                if (&valid) begin
`ifdef SOC_BRAM_ARB_RR_EN
                    // Favour the port that did not win last time
                    ready = last_grant ? 2'b01 : 2'b10;
`else
                    ready = 2'b01;
`endif
                end else begin
                    ready = valid;
                end
            end
        endcase
    end

    // Remember whoever is accepted this cycle; hold otherwise
    assign last_grant_nxt = (|ready) ? ready[PORT_DMA] : last_grant;

endmodule

// File: rtl/soc_bram_arb.sv
// Arbiter/sequencer for one single-port block RAM shared by CPU (port 0) and DMA (port 1).
// Latency: 2 edges from accept to rsp_valid pulse, reads and writes alike; one accept per cycle.
// Backpressure: per-port req_ready (burst lock can hold off the other port); responses cannot stall.
//
// Ports: clk, rst_n (async active-low), bus (soc_bram_arb_if.slave).
// Build option SOC_BRAM_ARB_RR_EN selects round-robin contention (see soc_bram_arb_grant).
// The RAM itself (registered dout) is instantiated by the parent and wired to bus.bram_*.
module soc_bram_arb
    import soc_bram_arb_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    soc_bram_arb_if.slave  bus
);

    logic [1:0]            state;
    logic                  last_grant;
    logic                  last_grant_nxt;
    logic [1:0]            ready;
    logic                  accept;
    logic                  sel;
    logic                  sel_we;
    logic                  sel_lock;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_wdata;
    logic                  bram_we_q;
    logic [addr_width-1:0] bram_addr_q;
    logic [data_width-1:0] bram_din_q;
    tag_t                  tag1;
    tag_t                  tag2;

    soc_bram_arb_grant u_grant (
        .valid          (bus.req_valid),
        .state          (state),
        .last_grant     (last_grant),
        .ready          (ready),
        .last_grant_nxt (last_grant_nxt)
    );

    assign bus.req_ready = ready;

    // ready is one-hot or zero, so bit 1 alone identifies the winner
    assign accept    = |(bus.req_valid & ready);
    assign sel       = ready[PORT_DMA];
    assign sel_we    = bus.req_we[sel];
    assign sel_lock  = bus.req_lock[sel];
    assign sel_addr  = sel ? bus.req_addr1  : bus.req_addr0;
    assign sel_wdata = sel ? bus.req_wdata1 : bus.req_wdata0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= PORT_DMA;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            tag1        <= '0;
            tag2        <= '0;
        end else begin
            // Idle cycles issue a harmless read at the held address
            bram_we_q  <= accept & sel_we;
            if (accept) begin
                bram_addr_q <= sel_addr;
                bram_din_q  <= sel_wdata;
                if (sel_lock) begin
                    state <= sel ? ST_LOCK1 : ST_LOCK0;
                end else begin
                    state <= ST_IDLE;
                end
            end
            last_grant <= last_grant_nxt;
            tag1       <= '{vld: accept, port: sel & accept, we: sel_we & accept};
            tag2       <= tag1;
        end
    end

    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;

    // tag2 lines up with the cycle in which the RAM's registered dout is valid
    assign bus.rsp_valid = {tag2.vld & tag2.port, tag2.vld & ~tag2.port};
    assign bus.rsp_we    = tag2.we;
    assign bus.rsp_rdata = bus.bram_dout;

endmodule

// File: tb/tb_soc_bram_arb.sv
// Bench for soc_bram_arb with a registered-output RAM model and a queue-based reference.
module tb_soc_bram_arb;

    localparam bit RR =
`ifdef SOC_BRAM_ARB_RR_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        int       due;
        bit       port;
        bit       we;
        bit [7:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    soc_bram_arb_if #(.addr_width(8), .data_width(8)) bus ();

    soc_bram_arb #(.addr_width(8), .data_width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Single-port RAM with registered dout
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (bus.bram_we) ram[bus.bram_addr] <= bus.bram_din;
        bus.bram_dout <= ram[bus.bram_addr];
    end

    // Reference model: memory contents, lock owner, last winner, expected responses
    bit [7:0] mmem [256];
    int       lock_owner;
    bit       model_last;
    bit       exp_bram_we;
    rsp_t     rq [$];
    int       cyc;
    int       acc_port;
    int       total;
    int       passes;
    int       fails;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic set_p(input int i, input bit v, input bit we, input bit lock,
                         input bit [7:0] addr, input bit [7:0] data);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_lock[i]  = lock;
        if (i == 0) begin
            bus.req_addr0  = addr;
            bus.req_wdata0 = data;
        end else begin
            bus.req_addr1  = addr;
            bus.req_wdata1 = data;
        end
    endtask

    task automatic model_reset();
        rq.delete();
        lock_owner  = -1;
        model_last  = 1'b1;
        exp_bram_we = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; advances to the next negedge.
    task automatic step();
        logic [1:0] v;
        logic [1:0] exp_rdy;
        logic [1:0] exp_rv;
        bit         exp_we;
        bit [7:0]   exp_d;
        bit         p;
        bit         we;
        bit [7:0]   a;
        rsp_t       e;
        #1;
        exp_rv = 2'b00;
        exp_we = 1'b0;
        exp_d  = 8'h00;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e      = rq.pop_front();
            exp_rv = e.port ? 2'b10 : 2'b01;
            exp_we = e.we;
            exp_d  = e.data;
        end
        check("rsp_valid", bus.rsp_valid, exp_rv);
        if (exp_rv != 2'b00) begin
            check("rsp_we", bus.rsp_we, exp_we);
            if (!exp_we) check("rsp_rdata", bus.rsp_rdata, exp_d);
        end
        check("bram_we", bus.bram_we, exp_bram_we);

        v = bus.req_valid;
        if (lock_owner >= 0)  exp_rdy = v[lock_owner] ? (2'b01 << lock_owner) : 2'b00;
        else if (v == 2'b11)  exp_rdy = (RR && !model_last) ? 2'b10 : 2'b01;
        else                  exp_rdy = v;
        check("req_ready", bus.req_ready, exp_rdy);

        acc_port    = -1;
        exp_bram_we = 1'b0;
        if (exp_rdy != 2'b00) begin
            p          = exp_rdy[1];
            acc_port   = p;
            model_last = p;
            lock_owner = bus.req_lock[p] ? int'(p) : -1;
            we         = bus.req_we[p];
            a          = p ? bus.req_addr1 : bus.req_addr0;
            if (we) mmem[a] = p ? bus.req_wdata1 : bus.req_wdata0;
            e.due  = cyc + 2;
            e.port = p;
            e.we   = we;
            e.data = we ? 8'h00 : mmem[a];
            rq.push_back(e);
            exp_bram_we = we;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bram_we"},   bus.bram_we,   0);
        check({tag, "_bram_addr"}, bus.bram_addr, 0);
        check({tag, "_bram_din"},  bus.bram_din,  0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_we"},    bus.rsp_we,    0);
    endtask

    task automatic idle(input int n);
        set_p(0, 0, 0, 0, 0, 0);
        set_p(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) step();
    endtask

    int grants [4];
    int exp_grants [4];
    bit pend [2];

    initial begin
        total = 0; passes = 0; fails = 0; cyc = 0;
        for (int k = 0; k < 256; k++) begin
            ram[k]  = 8'h00;
            mmem[k] = 8'h00;
        end
        rst_n = 1'b0;
        set_p(0, 0, 0, 0, 0, 0);
        set_p(1, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 write then read of the same word
        set_p(0, 1, 1, 0, 8'h12, 8'hA5); step();
        set_p(0, 1, 0, 0, 8'h12, 8'h00); step();
        idle(3);

        // Port 1 alone so that port 0 is favoured on the next contention
        set_p(1, 1, 0, 0, 8'h02, 8'h00); step();
        idle(2);

        // Both ports reading for four cycles
        exp_grants = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        set_p(0, 1, 0, 0, 8'h01, 8'h00);
        set_p(1, 1, 0, 0, 8'h02, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step();
            grants[k] = acc_port;
        end
        for (int k = 0; k < 4; k++) check("contention_grant", grants[k], exp_grants[k]);
        idle(3);

        // Port 1 locked write burst while port 0 waits
        set_p(1, 1, 1, 1, 8'h40, 8'h90); step();
        set_p(0, 1, 0, 0, 8'h40, 8'h00);
        for (int k = 1; k < 4; k++) begin
            set_p(1, 1, 1, (k < 3), 8'h40 + 8'(k), 8'h90 + 8'(k));
            step();
            check("burst_p1_accepted", acc_port, 1);
        end
        set_p(1, 0, 0, 0, 0, 0);
        #1;
        check("after_burst_p0_ready", bus.req_ready, 2'b01);
        step();
        idle(3);

        // Back-to-back write then read of the same address
        set_p(0, 1, 1, 0, 8'h07, 8'h3C); step();
        check("b2b_first", acc_port, 0);
        set_p(0, 1, 0, 0, 8'h07, 8'h00); step();
        check("b2b_second", acc_port, 0);
        idle(3);

        // Lock held across idle cycles of the owner
        set_p(1, 1, 1, 1, 8'h50, 8'h5A); step();
        set_p(1, 0, 0, 0, 0, 0);
        set_p(0, 1, 0, 0, 8'h50, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step();
            check("lock_gap_no_accept", acc_port, -1);
        end
        set_p(1, 1, 1, 0, 8'h51, 8'h5B); step();
        check("lock_end_p1", acc_port, 1);
        set_p(1, 0, 0, 0, 0, 0);
        step();
        check("lock_end_p0", acc_port, 0);
        idle(3);

        // Reset one cycle after accepting a read: nothing must come back
        set_p(0, 1, 0, 0, 8'h12, 8'h00); step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        set_p(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Randomized traffic; a pending request is held until its handshake
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    set_p(i, ($urandom_range(0, 99) < 60), $urandom_range(0, 1),
                          ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)),
                          8'($urandom_range(0, 255)));
                end
            end
            step();
            for (int i = 0; i < 2; i++) pend[i] = bus.req_valid[i] && (acc_port != i);
        end
        // Finish any open lock so the drain is clean
        for (int k = 0; k < 8 && lock_owner >= 0; k++) begin
            set_p(lock_owner, 1, 0, 0, 8'h00, 8'h00);
            set_p(1 - lock_owner, 0, 0, 0, 0, 0);
            step();
        end
        idle(4);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
